// File: rtl/morse_pkg.sv
// ============================================================================
// Module   : morse_pkg
// Purpose  : Shared state encoding and Morse timing multiples for morse_tx.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package morse_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_MARK     = 3'd1;
    localparam state_t ST_GAP      = 3'd2;
    localparam state_t ST_CHAR_GAP = 3'd3;
    localparam state_t ST_WORD_GAP = 3'd4;

    localparam logic [2:0] MAX_LEN  = 3'd5;

    localparam logic [2:0] DOT      = 3'd1;
    localparam logic [2:0] DASH     = 3'd3;
    localparam logic [2:0] ELEM_GAP = 3'd1;
    localparam logic [2:0] CHAR_GAP = 3'd3;
    localparam logic [2:0] WORD_GAP = 3'd7;

    function automatic logic [2:0] clamp_len(input logic [2:0] len);
        return (len > MAX_LEN) ? MAX_LEN : len;
    endfunction

endpackage

`default_nettype wire

// File: rtl/morse_unit_timer.sv
// ============================================================================
// Module   : morse_unit_timer
// Purpose  : Free-running unit tick generator, realigned by start.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_unit_timer #(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    output logic tick
);

    localparam logic [15:0] c_last = 16'(UNIT_CYCLES - 1);

    logic [15:0] r_count;

    // tick marks the final cycle of each unit; the count wraps so units stay
    // aligned across state changes without restarting the timer
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (start || (r_count == c_last)) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 16'd1;
        end
    end

    assign tick = (r_count == c_last);

endmodule

`default_nettype wire

// File: rtl/morse_tx.sv
// ============================================================================
// Module   : morse_tx
// Purpose  : Morse code keyer: turns (len, pattern) characters into key timing.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module morse_tx
    import morse_pkg::*;
#(
    parameter int unsigned UNIT_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] in_len,
    input  logic [4:0] in_pattern,
    output logic       key,
    output logic       busy,
    output logic       done
);

    state_t     r_state;
    state_t     w_next_state;
    logic [2:0] r_len;
    logic [4:0] r_pat;
    logic [2:0] r_idx;
    logic [2:0] r_units;
    logic       r_key;
    logic       r_done;
    logic       r_armed;

    logic       w_tick;
    logic       w_xfer;
    logic [2:0] w_need;
    logic       w_unit_done;
    logic       w_last_elem;
    logic       w_key_next;
    logic       w_done_next;

    assign w_xfer      = in_valid && in_ready;
    assign w_last_elem = (r_idx == (r_len - 3'd1));
    assign w_unit_done = w_tick && (r_units == (w_need - 3'd1));

    morse_unit_timer #(
        .UNIT_CYCLES (UNIT_CYCLES)
    ) u_timer (
        .clock (clock),
        .reset (reset),
        .start (w_xfer),
        .tick  (w_tick)
    );

    always_comb begin
        w_need = DOT;
        case (r_state)
            ST_MARK:     w_need = r_pat[r_idx] ? DASH : DOT;
            ST_GAP:      w_need = ELEM_GAP;
            ST_CHAR_GAP: w_need = CHAR_GAP;
            ST_WORD_GAP: w_need = WORD_GAP;
            default:     w_need = DOT;
        endcase
    end

    // State register; key and done are registered from next-state so they
    // line up exactly with the state they belong to
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_key   <= 1'b0;
            r_done  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_key   <= w_key_next;
            r_done  <= w_done_next;
            r_armed <= 1'b1;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_xfer) begin
                    w_next_state = (in_len == 3'd0) ? ST_WORD_GAP : ST_MARK;
                end
            end
            ST_MARK: begin
                if (w_unit_done) begin
                    w_next_state = w_last_elem ? ST_CHAR_GAP : ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_unit_done) begin
                    w_next_state = ST_MARK;
                end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
                if (w_unit_done) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_key_next  = (w_next_state == ST_MARK);
        w_done_next = ((r_state == ST_CHAR_GAP) || (r_state == ST_WORD_GAP))
                      && (w_next_state == ST_IDLE);
        in_ready    = r_armed && (r_state == ST_IDLE);
        busy        = (r_state != ST_IDLE);
        key         = r_key;
        done        = r_done;
    end

    // Character capture, element index and unit-multiple counting
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_len   <= '0;
            r_pat   <= '0;
            r_idx   <= '0;
            r_units <= '0;
        end else if (w_xfer) begin
            r_len   <= clamp_len(in_len);
            r_pat   <= in_pattern;
            r_idx   <= '0;
            r_units <= '0;
        end else if (r_state != ST_IDLE) begin
            if (w_unit_done) begin
                r_units <= '0;
                if (r_state == ST_GAP) begin
                    r_idx <= r_idx + 3'd1;
                end
            end else if (w_tick) begin
                r_units <= r_units + 3'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_morse_tx.sv
// ============================================================================
// Module   : tb_morse_tx
// Purpose  : Self-checking bench for morse_tx against a key-waveform model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_morse_tx;

    localparam int U = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [2:0] in_len = '0;
    logic [4:0] in_pattern = '0;
    logic       in_ready;
    logic       key;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    bit exp_q[$];

    always #5 clock = ~clock;

    morse_tx #(
        .UNIT_CYCLES (U)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_len     (in_len),
        .in_pattern (in_pattern),
        .key        (key),
        .busy       (busy),
        .done       (done)
    );

    // Expected key level for every busy cycle after the transfer
    function automatic void build_model(input int len_in, input logic [4:0] pat);
        int len;
        len = (len_in > 5) ? 5 : len_in;
        exp_q.delete();
        if (len == 0) begin
            repeat (7 * U) exp_q.push_back(1'b0);
        end else begin
            for (int e = 0; e < len; e++) begin
                repeat ((pat[e] ? 3 : 1) * U) exp_q.push_back(1'b1);
                repeat (((e == len - 1) ? 3 : 1) * U) exp_q.push_back(1'b0);
            end
        end
    endfunction

    task automatic wait_ready();
        int k;
        k = 0;
        while (in_ready !== 1'b1 && k < 200) begin
            @(negedge clock);
            k++;
        end
        if (in_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_ready: in_ready=%b, required 1 within 200 cycles", in_ready);
        end
    endtask

    task automatic send_and_check(input int len, input logic [4:0] pat, input bit noise,
                                  input string name);
        wait_ready();
        in_valid   = 1'b1;
        in_len     = 3'(len);
        in_pattern = pat;
        build_model(len, pat);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (key !== exp_q[i] || busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: key=%b busy=%b done=%b in_ready=%b, required key=%b busy=1 done=0 in_ready=0",
                         name, i + 1, key, busy, done, in_ready, exp_q[i]);
            end
            if (noise) begin
                in_valid   = (i < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                in_len     = 3'($urandom);
                in_pattern = 5'($urandom);
            end
            @(negedge clock);
        end
        n_checks++;
        if (done !== 1'b1 || in_ready !== 1'b1 || busy !== 1'b0 || key !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done cycle %0d: done=%b in_ready=%b busy=%b key=%b, required done=1 in_ready=1 busy=0 key=0",
                     name, exp_q.size() + 1, done, in_ready, busy, key);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (key !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: key=%b busy=%b done=%b in_ready=%b, required all 0",
                     key, busy, done, in_ready);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_early: in_ready=%b, required 0", in_ready);
        end
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_edge: in_ready=%b busy=%b done=%b, required 1 0 0",
                     in_ready, busy, done);
        end
    endtask

    task automatic test_letters();
        send_and_check(2, 5'b00010, 1'b0, "letter_A");
        send_and_check(1, 5'b00000, 1'b0, "letter_E");
        send_and_check(0, 5'b10101, 1'b0, "word_space");
        send_and_check(7, 5'b11111, 1'b0, "clamp_len7");
        send_and_check(6, 5'b01101, 1'b1, "clamp_len6");
    endtask

    task automatic test_back_to_back();
        bit exp_key;
        bit exp_done;
        wait_ready();
        in_valid   = 1'b1;
        in_len     = 3'd1;
        in_pattern = 5'b00001;
        @(posedge clock);
        @(negedge clock);
        for (int c = 1; c <= 50; c++) begin
            exp_key  = (c <= 12) || (c >= 26 && c <= 37);
            exp_done = (c == 25) || (c == 50);
            n_checks++;
            if (key !== exp_key || done !== exp_done || in_ready !== exp_done) begin
                n_fail++;
                $display("FAIL back_to_back cycle %0d: key=%b done=%b in_ready=%b, required key=%b done=%b in_ready=%b",
                         c, key, done, in_ready, exp_key, exp_done, exp_done);
            end
            if (c == 26) in_valid = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset_mid();
        wait_ready();
        in_valid   = 1'b1;
        in_len     = 3'd2;
        in_pattern = 5'b00010;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        repeat (9) @(negedge clock);
        n_checks++;
        if (key !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_pre: key=%b at cycle 10, required 1", key);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (key !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_async: key=%b busy=%b in_ready=%b done=%b, required all 0",
                     key, busy, in_ready, done);
        end
        repeat (3) @(negedge clock);
        reset = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_release_early: in_ready=%b, required 0", in_ready);
        end
        @(negedge clock);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_release_edge: in_ready=%b, required 1", in_ready);
        end
        for (int c = 0; c < 40; c++) begin
            n_checks++;
            if (done !== 1'b0 || key !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_discard cycle %0d: done=%b key=%b busy=%b, required 0 0 0",
                         c, done, key, busy);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_random();
        int len;
        logic [4:0] pat;
        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(0, 7);
            pat = 5'($urandom);
            send_and_check(len, pat, 1'b1, "random");
        end
    endtask

    initial begin
        test_reset();
        test_letters();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/morse_tx.md
MORSE_TX -- requirements
Module: morse_tx

Interface
REQ-001 SHALL provide parameter UNIT_CYCLES, default 4: clock cycles per Morse time unit, legal range 1 to 65535.
REQ-002 SHALL provide port clock  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL provide port in_valid  input  1  character available on in_len/in_pattern.
REQ-005 SHALL provide port in_ready  output  1  block can accept a character this cycle.
REQ-006 SHALL provide port in_len  input  3  element count, 0 to 5; 0 means word space.
REQ-007 SHALL provide port in_pattern  input  5  element kinds, LSB first; 1 = dash, 0 = dot.
REQ-008 SHALL provide port key  output  1  tone line; 1 = carrier on.
REQ-009 SHALL provide port busy  output  1  high whenever the state is not IDLE.
REQ-010 SHALL provide port done  output  1  one-cycle pulse when a character or space completes.

Function
REQ-011 SHALL implement the states IDLE, MARK, GAP, CHAR_GAP and WORD_GAP.
REQ-012 SHALL assert in_ready only in IDLE; a transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-013 SHALL capture in_len and in_pattern on transfer and ignore both inputs until the next IDLE.
REQ-014 SHALL clamp in_len values 6 and 7 to 5.
REQ-015 SHALL, on transfer with in_len nonzero, enter MARK at element 0 on the next cycle, with key=1 in that cycle (1-cycle latency).
REQ-016 SHALL, on transfer with in_len zero, enter WORD_GAP for 7 units with key=0.
REQ-017 SHALL hold MARK for 1 unit for a dot and 3 units for a dash.
REQ-018 SHALL, after a MARK that is not the last element, enter GAP for 1 unit with key=0, then advance the element index and return to MARK.
REQ-019 SHALL, after the last MARK, enter CHAR_GAP for 3 units with key=0.
REQ-020 SHALL, at the end of CHAR_GAP or WORD_GAP, return to IDLE and pulse done in that first IDLE cycle.
REQ-021 SHALL accept a new character in the same cycle that done pulses if in_valid is high (back-to-back, no dead cycle).
REQ-022 SHALL drive key=1 only in MARK, with no glitch at state boundaries because key is registered.
REQ-023 SHALL size the unit counter at 16 bits and the unit-multiple counter at 3 bits, with no wrap-around inside a legal duration.

Reset
REQ-024 SHALL, while reset is low, force state=IDLE, key=0, busy=0, done=0, in_ready=0 and clear all counters, asynchronously.
REQ-025 SHALL set in_ready=1 on the first rising edge after reset deasserts.
REQ-026 SHALL, on reset mid-character, drop key within the same cycle and discard the character without a done pulse.

Structure
REQ-027 SHALL place the state encoding, MAX_LEN=5 and the unit multiples (DOT=1, DASH=3, ELEM_GAP=1, CHAR_GAP=3, WORD_GAP=7) in shared package morse_pkg.
REQ-028 SHALL implement the unit tick generator as sub-module morse_unit_timer, parameterised by UNIT_CYCLES, with start and tick signals.

Verification
REQ-029 SHALL verify 'A' (in_len=2, in_pattern=5'b00010, UNIT_CYCLES=4): transfer at cycle 0 -> key high 1-4, low 5-8, high 9-20, low 21-32; done and in_ready at 33.
REQ-030 SHALL verify 'E' (in_len=1, in_pattern=0) -> key high 4 cycles, low 12 cycles, done at cycle 17.
REQ-031 SHALL verify a word space (in_len=0) -> key low, busy high for 28 cycles, done at cycle 29.
REQ-032 SHALL verify back-to-back 'T','T' with in_valid held high -> second transfer in the done cycle of the first; key shows 12 on, 12 off, 12 on.
REQ-033 SHALL verify reset low at cycle 10 during 'A' -> key=0 immediately, no done pulse, in_ready=1 one edge after release.
REQ-034 SHALL verify in_len=7 with in_pattern=5'b11111 -> exactly 5 dashes, then CHAR_GAP; total 5*3+4+3=22 units (88 cycles).
